ice_trace_capture: RTL and testbench
====================================

# ice_trace_capture

Parametrised successor to the ICE CPU-status front end: registers the CPU pipeline ID (PID) to the emulator side and adds a trace buffer recording every CPU write cycle (PID, debug-generator code, port data) with optional trigger and stop-freeze. Sits between the CPU core status pins and the ICE host interface. Provides buffered, host-readable write trace in place of raw pin pass-through.

## Interface
Parameters:
- PID_W, 2, CPU pipeline-ID width
- DGEN_W, 3, debug-generator code width
- PORT_W, 8, captured port-data width
- DEPTH, 16, trace entries; power of two, >= 2
- MODE, 0, 0 = stop when full, 1 = wrap (overwrite oldest)

Ports:
- CLK  in  1  clock; one clock, all logic on rising edge
- RES  in  1  reset, synchronous, active-high
- STPST  in  1  CPU stop status; high freezes PID and blocks capture
- CPUPID  in  PID_W  CPU pipeline ID
- PID  out  PID_W  registered PID to emulator
- CPUWR  in  1  CPU write strobe, one cycle per write
- DGEN  in  DGEN_W  debug-generator code for the current cycle
- PDATA  in  PORT_W  port data for the current cycle
- ARM  in  1  pulse: start a capture session
- CLR  in  1  pulse: flush buffer, return to IDLE
- TRG_EN  in  1  1 = wait for trigger after ARM
- TRG_PAT  in  DGEN_W  trigger pattern compared with DGEN
- RD  in  1  pop request
- RDATA  out  PID_W+DGEN_W+PORT_W  {PID, DGEN, PDATA} of popped entry
- RVALID  out  1  RDATA valid
- CNT  out  log2(DEPTH)+1  entries held
- EMPTY, FULL  out  1  buffer status
- OVF  out  1  sticky: entry overwritten (MODE 1 only)
- STATE  out  2  IDLE=0, ARMED=1, CAPTURE=2, FROZEN=3

## Operation
- PID register: loads CPUPID each cycle while STPST=0; holds while STPST=1.
- Write event W = CPUWR & ~STPST. Entry = {CPUPID, DGEN, PDATA} sampled the same cycle.
- FSM:
  - IDLE: ARM -> ARMED if TRG_EN=1, else CAPTURE. No capture.
  - ARMED: W & (DGEN==TRG_PAT) -> write entry, go CAPTURE. Other writes ignored.
  - CAPTURE: every W writes an entry.
  - FROZEN: no capture; reads allowed; exits only on CLR/RES.
- Full handling (CAPTURE):
  - MODE 0: a W that fills the last slot writes, then goes FROZEN next cycle. No write while FULL.
  - MODE 1: W while FULL overwrites oldest (read pointer advances), CNT unchanged, OVF set.
- Read: RD & ~EMPTY pops oldest; RD while EMPTY ignored, RVALID stays 0.
- Simultaneous W and RD:
  - Not full: both performed; CNT unchanged.
  - Full, MODE 1: pop returns the oldest entry, new entry written, OVF not set.
  - Full, MODE 0 in FROZEN: read only.
- Priority: RES > CLR > ARM > W/RD. CLR empties buffer, clears OVF, goes IDLE, drops any same-cycle W/RD. ARM outside IDLE is ignored.
- Pointers wrap mod DEPTH; CNT saturates at DEPTH by construction.

## Timing
- Reset values: PID=0, RDATA=0, RVALID=0, CNT=0, EMPTY=1, FULL=0, OVF=0, STATE=IDLE.
- PID latency: 1 cycle from CPUPID.
- Write at cycle N: CNT, EMPTY, FULL, STATE updated at N+1.
- RD at cycle N: RDATA and RVALID valid at N+1 for one cycle. RDATA holds its last value when RVALID=0.
- ARM at N: STATE changes at N+1. A W in cycle N is not captured.
- STPST high mid-session: capture paused, state retained. Resumes on the first W after STPST falls.
- RES or CLR mid-session: everything back to reset values next cycle; buffer contents discarded.

## Test plan
- Reset, then CPUPID=2'b10 with STPST=0 -> PID=2'b10 one cycle later. Raise STPST, change CPUPID -> PID holds 2'b10.
- DEPTH=16, MODE 0, TRG_EN=0: ARM, then 16 CPUWR with PDATA=0..15 -> FULL=1, STATE=FROZEN. A 17th write is ignored. 16 RD pulses return PDATA 0..15 in order with RVALID; then EMPTY=1.
- MODE 1: 20 writes with PDATA=0..19 -> CNT=16, OVF=1. Reads return 4..19.
- TRG_EN=1, TRG_PAT=3'b101: writes with DGEN=1,2,5,6 -> only the DGEN=5 and DGEN=6 entries are captured; STATE goes ARMED->CAPTURE on the DGEN=5 write.
- CPUWR with STPST=1 -> CNT unchanged. Same-cycle W and RD with CNT=5 -> CNT stays 5 and the oldest entry is returned.
- CLR asserted together with W and RD while holding 8 entries -> next cycle CNT=0, EMPTY=1, OVF=0, STATE=IDLE, RVALID=0.

Source files
------------

// File: rtl/ice_trace_capture.sv
// CPU write-trace capture for the ICE front end: registered PID plus a DEPTH-entry trace FIFO with trigger/freeze.
// Latency: PID, status and pop data appear one cycle after the causing input; there is no backpressure, MODE picks freeze-on-full or overwrite-oldest.
module ice_trace_capture #(
  parameter int PID_W  = 2,
  parameter int DGEN_W = 3,
  parameter int PORT_W = 8,
  parameter int DEPTH  = 16,
  parameter int MODE   = 0
) (
  input  logic                            CLK,
  input  logic                            RES,
  input  logic                            STPST,
  input  logic [PID_W-1:0]                CPUPID,
  output logic [PID_W-1:0]                PID,
  input  logic                            CPUWR,
  input  logic [DGEN_W-1:0]               DGEN,
  input  logic [PORT_W-1:0]               PDATA,
  input  logic                            ARM,
  input  logic                            CLR,
  input  logic                            TRG_EN,
  input  logic [DGEN_W-1:0]               TRG_PAT,
  input  logic                            RD,
  output logic [PID_W+DGEN_W+PORT_W-1:0]  RDATA,
  output logic                            RVALID,
  output logic [$clog2(DEPTH):0]          CNT,
  output logic                            EMPTY,
  output logic                            FULL,
  output logic                            OVF,
  output logic [1:0]                      STATE
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = PID_W + DGEN_W + PORT_W;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    FROZEN  = 2'd3
  } state_t;

  state_t        state;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_nxt;
  logic          ovf;
  logic          wr_ev;
  logic          room;
  logic          full;
  logic          empty;
  logic          cap;
  logic          pop;
  logic          inc;

  assign wr_ev = CPUWR & ~STPST;
  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign room  = (MODE == 1) || !full;

  always_comb begin
    cap = 1'b0;
    if (!RES && !CLR) begin
      case (state)
        ARMED:   cap = wr_ev && (DGEN == TRG_PAT) && room;
        CAPTURE: cap = wr_ev && room;
        default: cap = 1'b0;
      endcase
    end
  end

  assign pop = !RES && !CLR && RD && !empty;
  // A capture into a full buffer evicts the oldest entry, so the count only grows when there is a free slot or a pop.
  assign inc = cap && (!full || pop);
  assign cnt_nxt = cnt + (AW+1)'(inc) - (AW+1)'(pop);

  always_ff @(posedge CLK) begin
    if (cap) begin
      mem[wr_ptr] <= {CPUPID, DGEN, PDATA};
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      PID <= '0;
    end else if (!STPST) begin
      PID <= CPUPID;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES || CLR) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      RDATA  <= '0;
      RVALID <= 1'b0;
    end else begin
      RVALID <= pop;
      if (pop) begin
        RDATA <= mem[rd_ptr];
      end
      if (cap) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop || (cap && full)) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (cap && full && !pop) begin
        ovf <= 1'b1;
      end
      cnt <= cnt_nxt;
      case (state)
        IDLE: begin
          if (ARM) begin
            state <= TRG_EN ? ARMED : CAPTURE;
          end
        end
        ARMED: begin
          if (cap) begin
            state <= (MODE == 0 && cnt_nxt == FULL_CNT) ? FROZEN : CAPTURE;
          end
        end
        CAPTURE: begin
          if (MODE == 0 && cnt_nxt == FULL_CNT) begin
            state <= FROZEN;
          end
        end
        default: state <= state;
      endcase
    end
  end

  assign CNT   = cnt;
  assign EMPTY = empty;
  assign FULL  = full;
  assign OVF   = ovf;
  assign STATE = state;

endmodule

// File: tb/tb_ice_trace_capture.sv
// Bench for ice_trace_capture: a MODE 0 and a MODE 1 instance share stimulus and are checked every cycle against a queue model.
module tb_ice_trace_capture;
  localparam int DEPTH = 16;

  logic       CLK = 1'b0;
  logic       RES = 1'b1;
  logic       STPST = 1'b0;
  logic [1:0] CPUPID = '0;
  logic       CPUWR = 1'b0;
  logic [2:0] DGEN = '0;
  logic [7:0] PDATA = '0;
  logic       ARM = 1'b0;
  logic       CLR = 1'b0;
  logic       TRG_EN = 1'b0;
  logic [2:0] TRG_PAT = '0;
  logic       RD = 1'b0;

  logic [1:0]  pid_o    [2];
  logic [12:0] rdata_o  [2];
  logic        rvalid_o [2];
  logic [4:0]  cnt_o    [2];
  logic        empty_o  [2];
  logic        full_o   [2];
  logic        ovf_o    [2];
  logic [1:0]  state_o  [2];

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ice_trace_capture #(.PID_W(2), .DGEN_W(3), .PORT_W(8), .DEPTH(DEPTH), .MODE(g)) u_dut (
      .CLK(CLK), .RES(RES), .STPST(STPST), .CPUPID(CPUPID), .PID(pid_o[g]),
      .CPUWR(CPUWR), .DGEN(DGEN), .PDATA(PDATA), .ARM(ARM), .CLR(CLR),
      .TRG_EN(TRG_EN), .TRG_PAT(TRG_PAT), .RD(RD), .RDATA(rdata_o[g]),
      .RVALID(rvalid_o[g]), .CNT(cnt_o[g]), .EMPTY(empty_o[g]), .FULL(full_o[g]),
      .OVF(ovf_o[g]), .STATE(state_o[g])
    );
  end

  // Reference model: trace buffer as a queue, state as 0..3.
  logic [12:0] mq [2][$];
  int          m_st     [2];
  bit          m_ovf    [2];
  bit          m_rvalid [2];
  logic [12:0] m_rdata  [2];
  logic [1:0]  m_pid    [2];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      bit w;
      bit pop;
      bit cap;
      logic [12:0] e;
      e = {CPUPID, DGEN, PDATA};
      if (RES) begin
        mq[m].delete();
        m_st[m] = 0; m_ovf[m] = 0; m_rvalid[m] = 0; m_rdata[m] = '0; m_pid[m] = '0;
        continue;
      end
      if (!STPST) m_pid[m] = CPUPID;
      if (CLR) begin
        mq[m].delete();
        m_st[m] = 0; m_ovf[m] = 0; m_rvalid[m] = 0; m_rdata[m] = '0;
        continue;
      end
      w = CPUWR && !STPST;
      cap = 0;
      if (m_st[m] == 0) begin
        if (ARM) m_st[m] = TRG_EN ? 1 : 2;
      end else if (m_st[m] == 1) begin
        if (w && DGEN == TRG_PAT) begin cap = 1; m_st[m] = 2; end
      end else if (m_st[m] == 2) begin
        cap = w;
      end
      pop = RD && (mq[m].size() > 0);
      m_rvalid[m] = pop;
      if (pop) m_rdata[m] = mq[m].pop_front();
      if (cap) begin
        if (mq[m].size() == DEPTH) begin
          if (m == 1) begin
            void'(mq[m].pop_front());
            m_ovf[m] = 1;
            mq[m].push_back(e);
          end
        end else begin
          mq[m].push_back(e);
        end
      end
      if (m == 0 && m_st[m] == 2 && mq[m].size() == DEPTH) m_st[m] = 3;
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      string s;
      s = $sformatf("m%0d", m);
      chk({s, "_pid"},    pid_o[m],    m_pid[m]);
      chk({s, "_rvalid"}, rvalid_o[m], m_rvalid[m]);
      chk({s, "_rdata"},  rdata_o[m],  m_rdata[m]);
      chk({s, "_cnt"},    cnt_o[m],    mq[m].size());
      chk({s, "_empty"},  empty_o[m],  mq[m].size() == 0);
      chk({s, "_full"},   full_o[m],   mq[m].size() == DEPTH);
      chk({s, "_ovf"},    ovf_o[m],    m_ovf[m]);
      chk({s, "_state"},  state_o[m],  m_st[m]);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_step();
    #1;
    check_all();
  endtask

  task automatic wr(input logic [2:0] dg, input logic [7:0] pd);
    CPUWR = 1'b1; DGEN = dg; PDATA = pd; CPUPID = 2'($urandom);
    cyc();
    CPUWR = 1'b0;
  endtask

  task automatic rd1();
    RD = 1'b1;
    cyc();
    RD = 1'b0;
  endtask

  initial begin
    cyc(); cyc();
    chk("rst_cnt", cnt_o[0], 0);
    chk("rst_empty", empty_o[0], 1);
    RES = 1'b0;

    // PID follows CPUPID, frozen by STPST
    CPUPID = 2'b10; cyc();
    chk("pid_load", pid_o[0], 2'b10);
    STPST = 1'b1; CPUPID = 2'b01; cyc();
    chk("pid_hold", pid_o[0], 2'b10);
    STPST = 1'b0;

    // untriggered session, fill then overfill
    TRG_EN = 1'b0; ARM = 1'b1; cyc(); ARM = 1'b0;
    chk("arm_capture", state_o[0], 2);
    for (int i = 0; i < 16; i++) wr(3'(i), 8'(i));
    chk("m0_frozen", state_o[0], 3);
    chk("m0_full", full_o[0], 1);
    for (int i = 16; i < 20; i++) wr(3'(i), 8'(i));
    chk("m1_cnt16", cnt_o[1], 16);
    chk("m1_ovf", ovf_o[1], 1);
    for (int i = 0; i < 16; i++) begin
      rd1();
      chk("m0_rd_order", rdata_o[0][7:0], i);
      chk("m1_rd_order", rdata_o[1][7:0], i + 4);
    end
    chk("m0_drained", empty_o[0], 1);
    rd1();
    chk("rd_empty_rvalid", rvalid_o[0], 0);

    // triggered session
    CLR = 1'b1; cyc(); CLR = 1'b0;
    TRG_EN = 1'b1; TRG_PAT = 3'b101; ARM = 1'b1; cyc(); ARM = 1'b0;
    chk("armed", state_o[0], 1);
    wr(3'd1, 8'hA0); wr(3'd2, 8'hA1);
    chk("armed_hold", state_o[0], 1);
    wr(3'd5, 8'hA2);
    chk("trig_capture", state_o[0], 2);
    wr(3'd6, 8'hA3);
    chk("trig_cnt", cnt_o[0], 2);

    // stopped CPU write is not captured
    STPST = 1'b1; CPUWR = 1'b1; cyc(); CPUWR = 1'b0; STPST = 1'b0;
    chk("stpst_cnt", cnt_o[0], 2);
    wr(3'd0, 8'hB0); wr(3'd1, 8'hB1); wr(3'd2, 8'hB2);
    RD = 1'b1; wr(3'd3, 8'hB3); RD = 1'b0;
    chk("wr_rd_cnt", cnt_o[0], 5);
    chk("wr_rd_oldest", rdata_o[0], {m_rdata[0][12:11], 3'd5, 8'hA2});
    wr(3'd4, 8'hB4); wr(3'd4, 8'hB5); wr(3'd4, 8'hB6);
    chk("pre_clr_cnt", cnt_o[1], 8);

    // CLR beats simultaneous W and RD
    CLR = 1'b1; RD = 1'b1; wr(3'd7, 8'hC0); CLR = 1'b0; RD = 1'b0;
    chk("clr_cnt", cnt_o[1], 0);
    chk("clr_state", state_o[1], 0);
    chk("clr_rvalid", rvalid_o[1], 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      RES     = ($urandom_range(0, 399) == 0);
      CLR     = ($urandom_range(0, 299) == 0);
      ARM     = ($urandom_range(0, 9) == 0);
      TRG_EN  = 1'($urandom);
      if ($urandom_range(0, 19) == 0) TRG_PAT = 3'($urandom);
      STPST   = ($urandom_range(0, 7) == 0);
      CPUWR   = ($urandom_range(0, 1) == 0);
      RD      = ($urandom_range(0, 4) == 0);
      DGEN    = 3'($urandom);
      PDATA   = 8'($urandom);
      CPUPID  = 2'($urandom);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
